qcs_fir_iq_filt: RTL and testbench
==================================

// Module: qcs_fir_iq_filt
// PURPOSE
//  Complex-baseband FIR filter with optional decimation-by-2. Consumes the valid-qualified I/Q
//  sample stream (data_vld/data_i/data_q) and produces a filtered, rounded, saturated I/Q stream.
//  Identical real coefficients on both rails; I and Q are filtered independently.
//  Fixed-latency pipeline; the delay line advances only on accepted samples.
// PARAMETERS
//  DW     12              I/Q sample width, signed two's complement, in and out
//  CW     10              coefficient width, signed
//  NTAPS  8               number of taps, 2..32
//  COEF   {NTAPS{10'sd64}} packed coefficient array, COEF[0] = newest-sample tap
//  SHIFT  9               right shift applied to accumulator before rounding, >=1
//  DEC    1               decimation factor, 1 or 2 only
// PORTS
//  clk       in   1   single clock
//  reset_n   in   1   asynchronous active-low reset
//  data_vld  in   1   input sample valid, one sample per cycle max
//  data_i    in   DW  input I sample, signed
//  data_q    in   DW  input Q sample, signed
//  out_vld   out  1   output sample valid, single-cycle pulse per output
//  out_i     out  DW  filtered I, signed
//  out_q     out  DW  filtered Q, signed
//  out_sat   out  1   1 = I or Q of current output was saturated; qualified by out_vld
// BEHAVIOUR
//  - Reset (async assert, sync release): delay lines, pipeline regs, phase counter -> 0;
//    out_vld=0, out_i=0, out_q=0, out_sat=0. Reset mid-stream discards all in-flight samples.
//  - Delay line: on data_vld=1 shift in {data_i,data_q} at tap 0; no shift when data_vld=0.
//  - Pipeline (per rail): S1 tap-register update; S2 NTAPS products COEF[k]*x[k], width DW+CW;
//    S3 adder tree + round + saturate into output regs. out_vld asserts exactly 3 cycles after
//    the cycle data_vld=1 was sampled (DEC=1). Gaps in data_vld pass through as gaps.
//  - Accumulator width AW = DW+CW+$clog2(NTAPS); no internal overflow possible.
//  - Rounding: y = (acc + 2^(SHIFT-1)) >>> SHIFT (round half up, arithmetic shift).
//  - Saturation: y > 2^(DW-1)-1 -> 2^(DW-1)-1; y < -2^(DW-1) -> -2^(DW-1); out_sat=1
//    if either rail clipped, else 0. out_sat=0 whenever out_vld=0.
//  - out_i/out_q hold last value while out_vld=0.
//  - DEC=2: 1-bit phase counter toggles on each accepted sample; output produced only for
//    samples accepted with phase=1 (2nd, 4th, ...); latency unchanged for those samples.
//    Delay line still shifts on every accepted sample. Phase resets to 0 on reset only.
//  - Filter startup: taps hold 0 after reset; first NTAPS-1 outputs are partial sums (no flush).
//  - Back-to-back data_vld every cycle sustained indefinitely; no backpressure exists.
// TESTING
//  1 Impulse, defaults: data_i=512 one cycle then 0 (data_vld held 1), data_q=0 -> out_i=64 for
//    8 consecutive out_vld, then 0; out_q=0; first out_vld exactly 3 cycles after impulse.
//  2 DC gain, defaults: data_i=1000, data_q=-1000 continuous -> after 8 outputs out_i=1000,
//    out_q=-1000, out_sat=0.
//  3 Saturation, COEF all 127: data_i=2047, data_q=-2048 continuous -> steady out_i=2047,
//    out_q=-2048, out_sat=1; with data_i=100,data_q=0 -> out_i=198, out_sat=0.
//  4 Gapped input: data_vld 1-0-0-1-0-1 pattern with DC 1000 -> out_vld mirrors pattern delayed
//    3 cycles; values identical to gap-free run.
//  5 DEC=2: 10 accepted samples, DC 1000 -> exactly 5 out_vld pulses, on samples 2,4,6,8,10.
//  6 Reset mid-stream: assert reset_n=0 with 2 samples in flight -> out_vld=0 immediately,
//    no stale output after release; impulse after release reproduces test 1.

Source files
------------

// File: rtl/qcs_fir_iq_filt_if.sv
// I/Q stream bundle for qcs_fir_iq_filt: valid-qualified input samples and the
// filtered output samples with the saturation flag.
interface qcs_fir_iq_filt_if #(
  parameter int DW = 12
);
  logic                 data_vld;
  logic signed [DW-1:0] data_i;
  logic signed [DW-1:0] data_q;
  logic                 out_vld;
  logic signed [DW-1:0] out_i;
  logic signed [DW-1:0] out_q;
  logic                 out_sat;

  modport master (
    output data_vld, data_i, data_q,
    input  out_vld, out_i, out_q, out_sat
  );

  modport slave (
    input  data_vld, data_i, data_q,
    output out_vld, out_i, out_q, out_sat
  );
endinterface

// File: rtl/qcs_fir_iq_filt.sv
// Complex-baseband FIR (shared real coefficients on I and Q) with optional
// decimation-by-2; 3-stage pipeline: tap shift, products, sum/round/saturate.
module qcs_fir_iq_filt #(
  parameter int                     DW    = 12,
  parameter int                     CW    = 10,
  parameter int                     NTAPS = 8,
  parameter logic [NTAPS*CW-1:0]    COEF  = {NTAPS{CW'(64)}},
  parameter int                     SHIFT = 9,
  parameter int                     DEC   = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  qcs_fir_iq_filt_if.slave   bus
);

  localparam int PW  = DW + CW;
  localparam int AW  = DW + CW + $clog2(NTAPS);
  localparam int AW1 = AW + 1;

  localparam logic signed [AW:0]   HALF    = AW1'(1) << (SHIFT - 1);
  localparam logic signed [AW:0]   MAXV    = AW1'((2 ** (DW - 1)) - 1);
  localparam logic signed [AW:0]   MINV    = AW1'(-(2 ** (DW - 1)));
  localparam logic [DW-1:0]        MAX_OUT = {1'b0, {(DW-1){1'b1}}};
  localparam logic [DW-1:0]        MIN_OUT = {1'b1, {(DW-1){1'b0}}};

  logic signed [CW-1:0] coef   [NTAPS];
  logic signed [DW-1:0] tap_i  [NTAPS];
  logic signed [DW-1:0] tap_q  [NTAPS];
  logic signed [PW-1:0] prod_i [NTAPS];
  logic signed [PW-1:0] prod_q [NTAPS];
  logic                 vld1;
  logic                 vld2;
  logic                 phase;

  logic signed [AW-1:0] acc_i;
  logic signed [AW-1:0] acc_q;
  logic signed [AW:0]   y_i;
  logic signed [AW:0]   y_q;
  logic [DW:0]          sat_i;
  logic [DW:0]          sat_q;

  always_comb begin
    for (int unsigned k = 0; k < NTAPS; k++) begin
      coef[k] = COEF[k*CW +: CW];
    end
  end

  // Returns {clipped, value}.
  function automatic logic [DW:0] sat_fn(input logic signed [AW:0] y);
    if (y > MAXV) begin
      return {1'b1, MAX_OUT};
    end else if (y < MINV) begin
      return {1'b1, MIN_OUT};
    end else begin
      return {1'b0, y[DW-1:0]};
    end
  endfunction

  // S1: delay line advances only on accepted samples; in DEC=2 mode only the
  // odd-phase samples carry a valid token down the pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        tap_i[k] <= '0;
        tap_q[k] <= '0;
      end
      vld1  <= 1'b0;
      phase <= 1'b0;
    end else begin
      vld1 <= 1'b0;
      if (bus.data_vld) begin
        tap_i[0] <= bus.data_i;
        tap_q[0] <= bus.data_q;
        for (int unsigned k = 1; k < NTAPS; k++) begin
          tap_i[k] <= tap_i[k-1];
          tap_q[k] <= tap_q[k-1];
        end
        if (DEC == 2) begin
          phase <= ~phase;
          vld1  <= phase;
        end else begin
          phase <= 1'b0;
          vld1  <= 1'b1;
        end
      end
    end
  end

  // S2: per-tap products
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        prod_i[k] <= '0;
        prod_q[k] <= '0;
      end
      vld2 <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < NTAPS; k++) begin
        prod_i[k] <= PW'(tap_i[k]) * PW'(coef[k]);
        prod_q[k] <= PW'(tap_q[k]) * PW'(coef[k]);
      end
      vld2 <= vld1;
    end
  end

  always_comb begin
    acc_i = '0;
    acc_q = '0;
    for (int unsigned k = 0; k < NTAPS; k++) begin
      acc_i = acc_i + AW'(prod_i[k]);
      acc_q = acc_q + AW'(prod_q[k]);
    end
    y_i   = (AW1'(acc_i) + HALF) >>> SHIFT;
    y_q   = (AW1'(acc_q) + HALF) >>> SHIFT;
    sat_i = sat_fn(y_i);
    sat_q = sat_fn(y_q);
  end

  // S3: output registers hold their value between valid outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.out_vld <= 1'b0;
      bus.out_i   <= '0;
      bus.out_q   <= '0;
      bus.out_sat <= 1'b0;
    end else begin
      bus.out_vld <= vld2;
      if (vld2) begin
        bus.out_i   <= sat_i[DW-1:0];
        bus.out_q   <= sat_q[DW-1:0];
        bus.out_sat <= sat_i[DW] | sat_q[DW];
      end else begin
        bus.out_sat <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_qcs_fir_iq_filt.sv
// Scoreboard bench for qcs_fir_iq_filt: three instances (default, all-127
// coefficients, DEC=2) driven with directed vectors; a monitor pops expectations.
module tb_qcs_fir_iq_filt;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   pulses2 = 0;

  typedef struct {
    int i;
    int q;
    bit s;
    int c;
  } exp_t;

  exp_t sbq [3][$];
  int   hist_i [3][8];
  int   hist_q [3][8];
  bit   ph [3];

  qcs_fir_iq_filt_if #(.DW(12)) bi0 ();
  qcs_fir_iq_filt_if #(.DW(12)) bi1 ();
  qcs_fir_iq_filt_if #(.DW(12)) bi2 ();

  qcs_fir_iq_filt u0 (.clk(clk), .reset_n(reset_n), .bus(bi0.slave));
  qcs_fir_iq_filt #(.COEF({8{10'sd127}})) u1 (.clk(clk), .reset_n(reset_n), .bus(bi1.slave));
  qcs_fir_iq_filt #(.DEC(2)) u2 (.clk(clk), .reset_n(reset_n), .bus(bi2.slave));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rnd_sat(input int acc, output int y, output bit clip);
    y = (acc + 256) >>> 9;
    clip = 1'b0;
    if (y > 2047) begin y = 2047; clip = 1'b1; end
    if (y < -2048) begin y = -2048; clip = 1'b1; end
  endtask

  task automatic model_step(input int d, input bit v, input int xi, input int xq);
    int   c, ai, aq, yi, yq;
    bit   ci, cq, emit;
    exp_t e;
    if (!v) return;
    for (int k = 7; k > 0; k--) begin
      hist_i[d][k] = hist_i[d][k-1];
      hist_q[d][k] = hist_q[d][k-1];
    end
    hist_i[d][0] = xi;
    hist_q[d][0] = xq;
    c = (d == 1) ? 127 : 64;
    ai = 0;
    aq = 0;
    for (int k = 0; k < 8; k++) begin
      ai += c * hist_i[d][k];
      aq += c * hist_q[d][k];
    end
    rnd_sat(ai, yi, ci);
    rnd_sat(aq, yq, cq);
    emit = 1'b1;
    if (d == 2) begin
      emit = ph[d];
      ph[d] = ~ph[d];
    end
    if (emit) begin
      e.i = yi; e.q = yq; e.s = ci | cq; e.c = cyc + 3;
      sbq[d].push_back(e);
    end
  endtask

  task automatic clear_model();
    for (int d = 0; d < 3; d++) begin
      sbq[d].delete();
      ph[d] = 1'b0;
      for (int k = 0; k < 8; k++) begin
        hist_i[d][k] = 0;
        hist_q[d][k] = 0;
      end
    end
  endtask

  task automatic cycle(input int d, input bit v, input int xi, input int xq);
    bi0.data_vld = (d == 0) && v; bi0.data_i = 12'(xi); bi0.data_q = 12'(xq);
    bi1.data_vld = (d == 1) && v; bi1.data_i = 12'(xi); bi1.data_q = 12'(xq);
    bi2.data_vld = (d == 2) && v; bi2.data_i = 12'(xi); bi2.data_q = 12'(xq);
    model_step(d, v, xi, xq);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(0, 1'b0, 0, 0);
  endtask

  // Monitor: every presented output must match the head of its queue, on time.
  always @(negedge clk) begin
    bit vld [3];
    bit sat [3];
    int oi [3];
    int oq [3];
    exp_t e;
    vld[0] = bi0.out_vld; sat[0] = bi0.out_sat; oi[0] = bi0.out_i; oq[0] = bi0.out_q;
    vld[1] = bi1.out_vld; sat[1] = bi1.out_sat; oi[1] = bi1.out_i; oq[1] = bi1.out_q;
    vld[2] = bi2.out_vld; sat[2] = bi2.out_sat; oi[2] = bi2.out_i; oq[2] = bi2.out_q;
    if (vld[2]) pulses2++;
    for (int d = 0; d < 3; d++) begin
      if (vld[d]) begin
        if (sbq[d].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_vld dut%0d: got out_vld=1 out_i=%0d expected no output (cycle %0d)",
                   d, oi[d], cyc);
        end else begin
          e = sbq[d].pop_front();
          check($sformatf("dut%0d_cycle", d), cyc, e.c);
          check($sformatf("dut%0d_out_i", d), oi[d], e.i);
          check($sformatf("dut%0d_out_q", d), oq[d], e.q);
          check($sformatf("dut%0d_out_sat", d), int'(sat[d]), int'(e.s));
        end
      end else if (sat[d]) begin
        check($sformatf("dut%0d_sat_no_vld", d), 1, 0);
      end
    end
  end

  initial begin
    bi0.data_vld = 0; bi0.data_i = '0; bi0.data_q = '0;
    bi1.data_vld = 0; bi1.data_i = '0; bi1.data_q = '0;
    bi2.data_vld = 0; bi2.data_i = '0; bi2.data_q = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check("rst_vld", int'(bi0.out_vld), 0);
    check("rst_out_i", int'(bi0.out_i), 0);
    check("rst_out_q", int'(bi0.out_q), 0);
    check("rst_sat", int'(bi1.out_sat), 0);
    check("rst_vld2", int'(bi2.out_vld), 0);
    reset_n = 1'b1;
    idle(2);

    // impulse on I, defaults: eight outputs of 64 then zeros
    cycle(0, 1, 512, 0);
    for (int k = 0; k < 10; k++) cycle(0, 1, 0, 0);
    idle(4);
    check("impulse_tail_i", int'(bi0.out_i), 0);

    // DC gain
    for (int k = 0; k < 16; k++) cycle(0, 1, 1000, -1000);
    idle(5);
    check("dc_hold_i", int'(bi0.out_i), 1000);
    check("dc_hold_q", int'(bi0.out_q), -1000);

    // saturation with all-127 coefficients, then back into range
    for (int k = 0; k < 12; k++) cycle(1, 1, 2047, -2048);
    check("sat_stream_i", int'(bi1.out_i), 2047);
    check("sat_stream_q", int'(bi1.out_q), -2048);
    check("sat_stream_flag", int'(bi1.out_sat), 1);
    for (int k = 0; k < 12; k++) cycle(1, 1, 100, 0);
    idle(5);
    check("unsat_hold_i", int'(bi1.out_i), 198);
    check("unsat_hold_q", int'(bi1.out_q), 0);

    // DEC=2: ten samples give five outputs
    pulses2 = 0;
    for (int k = 0; k < 10; k++) cycle(2, 1, 1000, 1000);
    idle(5);
    check("dec2_pulses", pulses2, 5);
    check("dec2_hold_i", int'(bi2.out_i), 1000);

    // reset mid-stream with samples in flight
    for (int k = 0; k < 5; k++) cycle(0, 1, 300, -300);
    check("pre_rst_vld", int'(bi0.out_vld), 1);
    reset_n = 1'b0;
    clear_model();
    #1;
    check("midrst_vld", int'(bi0.out_vld), 0);
    check("midrst_out_i", int'(bi0.out_i), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    idle(6);
    cycle(0, 1, 512, 0);
    for (int k = 0; k < 9; k++) cycle(0, 1, 0, 0);
    idle(4);

    // gapped DC input: 1-0-0-1-0-1 pattern, outputs mirror it 3 cycles later
    for (int r = 0; r < 3; r++) begin
      cycle(0, 1, 1000, 1000);
      cycle(0, 0, 0, 0);
      cycle(0, 0, 0, 0);
      cycle(0, 1, 1000, 1000);
      cycle(0, 0, 0, 0);
      cycle(0, 1, 1000, 1000);
    end
    idle(5);
    check("gap_hold_i", int'(bi0.out_i), 1000);

    for (int d = 0; d < 3; d++) check($sformatf("dut%0d_queue_empty", d), sbq[d].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
